// File: rtl/emu_rst_pkg.sv
// Shared types for the emulator reset sequencer: FSM state encoding and hold default.
package emu_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        SW_RST    = 2'd2,
        RUN       = 2'd3
    } emu_rst_state_t;

    localparam int HOLD_CYCLES_DEF = 16;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser, async active-low reset to 0.
// Generic enough for any slow level signal crossing into clk (VIO probes, ext pins).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/emu_rst_ctrl.sv
// Emulator reset sequencer: holds emu_rst until the clock wizard is locked for HOLD_CYCLES.
// Optional lock-loss counter on loss_cnt, enabled by defining EMU_RST_LOSS_CNT_EN.
module emu_rst_ctrl
    import emu_rst_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             sw_rst,
    output logic             emu_rst,
    output logic             emu_run
`ifdef EMU_RST_LOSS_CNT_EN
    ,
    output logic [CNT_W-1:0] loss_cnt
`endif
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    emu_rst_state_t   state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             locked_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (locked_s)
    );

    // Loss of lock overrides everything else, including counter expiry.
    always_comb begin
        state_nxt = state;
        if (!locked_s) begin
            state_nxt = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: state_nxt = sw_rst ? SW_RST : HOLD;
                HOLD: begin
                    if (sw_rst)
                        state_nxt = SW_RST;
                    else if (cnt == '0)
                        state_nxt = RUN;
                end
                SW_RST:    if (!sw_rst) state_nxt = HOLD;
                RUN:       if (sw_rst)  state_nxt = SW_RST;
                default:   state_nxt = WAIT_LOCK;
            endcase
        end
    end

    // Outputs are registered from the next state so they move on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            emu_rst <= 1'b1;
            emu_run <= 1'b0;
        end else begin
            state   <= state_nxt;
            emu_rst <= (state_nxt != RUN);
            emu_run <= (state_nxt == RUN);
            if (state_nxt == HOLD && state != HOLD)
                cnt <= HOLD_LOAD;
            else if (state == HOLD && cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end

`ifdef EMU_RST_LOSS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            loss_cnt <= '0;
        else if (state != WAIT_LOCK && state_nxt == WAIT_LOCK && loss_cnt != '1)
            loss_cnt <= loss_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_emu_rst_ctrl.sv
// Bench for emu_rst_ctrl: two instances (HOLD_CYCLES=16/CNT_W=16 and HOLD_CYCLES=1/CNT_W=4)
// share stimulus and are compared each cycle against a streak-of-good-cycles model.
module tb_emu_rst_ctrl;

    localparam int H0 = 16;
    localparam int H1 = 1;
    localparam int W0 = 16;
    localparam int W1 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic locked = 1'b0;
    logic sw_rst = 1'b0;
    logic rst0, run0, rst1, run1;
`ifdef EMU_RST_LOSS_CNT_EN
    logic [W0-1:0] loss0;
    logic [W1-1:0] loss1;
`endif

    always #5 clk = ~clk;

    emu_rst_ctrl #(.HOLD_CYCLES(H0), .CNT_W(W0)) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .sw_rst(sw_rst),
        .emu_rst(rst0), .emu_run(run0)
`ifdef EMU_RST_LOSS_CNT_EN
        , .loss_cnt(loss0)
`endif
    );

    emu_rst_ctrl #(.HOLD_CYCLES(H1), .CNT_W(W1)) dut1 (
        .clk(clk), .rst_n(rst_n), .locked(locked), .sw_rst(sw_rst),
        .emu_rst(rst1), .emu_run(run1)
`ifdef EMU_RST_LOSS_CNT_EN
        , .loss_cnt(loss1)
`endif
    );

    // Model: the sequencer runs once H+1 consecutive edges saw a stable lock and no
    // sw reset; a loss is any falling edge of the synchronised lock after reset.
    logic s1, s2, ls_prev;
    int   streak, loss_m;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_reset();
        s1 = 1'b0; s2 = 1'b0; ls_prev = 1'b0; streak = 0; loss_m = 0;
    endtask

    task automatic check_all();
        chk("rst_h16", rst0, 32'(streak < H0 + 1));
        chk("run_h16", run0, 32'(streak >= H0 + 1));
        chk("rst_h1",  rst1, 32'(streak < H1 + 1));
        chk("run_h1",  run1, 32'(streak >= H1 + 1));
`ifdef EMU_RST_LOSS_CNT_EN
        chk("loss_w16", 32'(loss0), 32'(sat(loss_m, (1 << W0) - 1)));
        chk("loss_w4",  32'(loss1), 32'(sat(loss_m, (1 << W1) - 1)));
`endif
    endtask

    task automatic step();
        logic ls;
        @(posedge clk);
        if (rst_n) begin
            ls = s2;
            s2 = s1;
            s1 = locked;
            if (ls && !sw_rst) begin
                if (streak < 1000) streak++;
            end else begin
                streak = 0;
            end
            if (ls_prev && !ls) loss_m++;
            ls_prev = ls;
        end else begin
            model_reset();
        end
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Edges (first edge sampling the new inputs = 1) until emu_rst reaches val on each instance.
    task automatic meas(input string tag, input logic val, input int exp0, input int exp1);
        int f0 = -1;
        int f1 = -1;
        for (int n = 1; n <= 60 && (f0 < 0 || f1 < 0); n++) begin
            step();
            if (f0 < 0 && rst0 == val) f0 = n;
            if (f1 < 0 && rst1 == val) f1 = n;
        end
        chk({tag, "_h16"}, 32'(f0), 32'(exp0));
        chk({tag, "_h1"},  32'(f1), 32'(exp1));
    endtask

    initial begin
        int saw_run;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all();

        // Power-up
        steps(5);
        rst_n = 1'b1;
        steps(10);
        locked = 1'b1;
        meas("pwrup_fall", 1'b0, 19, 4);
        steps(10);

        // Lock loss in RUN for 20 cycles, then restore
        locked = 1'b0;
        meas("loss_rise", 1'b1, 3, 3);
        steps(17);
        locked = 1'b1;
        meas("relock_fall", 1'b0, 19, 4);
        steps(5);

        // Software reset pulse of 3 cycles
        sw_rst = 1'b1;
        meas("sw_rise", 1'b1, 1, 1);
        steps(2);
        sw_rst = 1'b0;
        meas("sw_fall", 1'b0, 17, 2);
        steps(5);

        // Lock drop seen on the same edge as sw_rst
        locked = 1'b0;
        steps(2);
        sw_rst = 1'b1;
        steps(3);
        sw_rst = 1'b0;
        steps(3);
        locked = 1'b1;
        steps(25);

        // Lock drop seen on the edge the hold counter would expire
        locked = 1'b0;
        steps(25);
        locked = 1'b1;
        steps(16);
        locked = 1'b0;
        saw_run = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (run0) saw_run++;
        end
        chk("cnt0_no_run", 32'(saw_run), 32'd0);

        // Async reset mid-HOLD (counter = 7)
        locked = 1'b1;
        steps(11);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_rst", rst0, 1'b1);
        chk("midrst_run", run0, 1'b0);
`ifdef EMU_RST_LOSS_CNT_EN
        chk("midrst_loss", 32'(loss0), 32'd0);
`endif
        steps(3);
        rst_n = 1'b1;
        meas("midrst_fall", 1'b0, 19, 4);

        // Randomised segments
        for (int seg = 0; seg < 60; seg++) begin
            locked = ($urandom_range(0, 3) != 0);
            sw_rst = ($urandom_range(0, 4) == 0);
            steps($urandom_range(1, 30));
        end
        sw_rst = 1'b0;

        // Forced losses to saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            locked = 1'b1;
            steps(5);
            locked = 1'b0;
            steps(4);
        end
`ifdef EMU_RST_LOSS_CNT_EN
        chk("loss_sat_w4", 32'(loss1), 32'd15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
